systolic_deskew: RTL and testbench

Output-side companion to the input skew delay lines of the systolic array. Rows leave the array skewed: lane i lags lane 0 by i cycles. This block delays each lane by the complement amount, so all lanes of a row appear on one cycle with one valid strobe. It also flags lanes that arrive out of step and counts the aligned rows it emits. It sits between the array's bottom/right edge and the result write-back path, and shares the array-wide `stall`.

---
 rtl/systolic_deskew.sv | 89 ++++++++
 tb/tb_systolic_deskew.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_deskew.sv
// systolic_deskew: realigns skewed lanes leaving the systolic array.
// Lane i lags lane 0 by i cycles on entry; lane i is delayed by LANES-1-i
// stages so a complete row lands in one common output register.
module systolic_deskew #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic                     err_misalign,
  output logic [COUNT_W-1:0]       row_count
);

  localparam int unsigned ROW_W = LANES * WIDTH;

  // Chain-end valids and data, one entry per lane.
  logic [LANES-1:0] end_v;
  logic [ROW_W-1:0] end_d;
  logic             all_v;
  logic             any_v;
  logic             valid_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned D = LANES - 1 - i;

    if (D == 0) begin : g_pass
      // The latest lane needs no delay and feeds the output register directly.
      assign end_v[i]               = in_valid[i];
      assign end_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_chain
      logic [D-1:0]     v;
      logic [WIDTH-1:0] d [D];

      // Delay chain for this lane; frozen as a whole while stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= '0;
          for (int k = 0; k < int'(D); k++) begin
            d[k] <= '0;
          end
        end else if (!stall) begin
          v[0] <= in_valid[i];
          d[0] <= in_data[i*WIDTH +: WIDTH];
          for (int k = 1; k < int'(D); k++) begin
            v[k] <= v[k-1];
            d[k] <= d[k-1];
          end
        end
      end

      assign end_v[i]               = v[D-1];
      assign end_d[i*WIDTH +: WIDTH] = d[D-1];
    end
  end

  assign all_v = &end_v;
  assign any_v = |end_v;

  // Common output register: emit complete rows, flag partial ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      out_data     <= '0;
      err_misalign <= 1'b0;
      row_count    <= '0;
    end else if (!stall) begin
      if (all_v) begin
        valid_q   <= 1'b1;
        out_data  <= end_d;
        row_count <= row_count + COUNT_W'(1);
      end else begin
        valid_q <= 1'b0;
        if (any_v) begin
          err_misalign <= 1'b1;
        end
      end
    end
  end

  // A held row is not offered downstream during a stall.
  assign out_valid = valid_q & ~stall;

endmodule

// File: tb/tb_systolic_deskew.sv
// tb_systolic_deskew: randomized and directed checks against a history model.
module tb_systolic_deskew;

  localparam int L    = 4;
  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int N    = L * W;
  localparam int SMAX = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [L-1:0]  in_valid;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          err_misalign;
  logic [CW-1:0] row_count;

  always #5 clk = ~clk;

  systolic_deskew #(.LANES(L), .WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .err_misalign(err_misalign),
    .row_count(row_count)
  );

  // Model: history of the last L accepted input samples plus output state.
  logic [L-1:0]  hv [L];
  logic [N-1:0]  hd [L];
  logic          m_valid;
  logic [N-1:0]  m_data;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  // Stimulus schedule in upstream (non-stalled) time.
  logic [L-1:0] sv [SMAX];
  logic [N-1:0] sd [SMAX];

  int n_vec, n_cmp, n_fail;
  int step_no, vcount, vfirst, vlast, base;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, step_no);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < L; k++) begin
      hv[k] = '0;
      hd[k] = '0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_cnt   = '0;
  endtask

  // A row element for lane i is the sample taken L-1-i accepted edges ago.
  task automatic model_edge(input logic [L-1:0] v, input logic [N-1:0] d);
    logic [L-1:0] vv;
    logic [N-1:0] row;
    for (int k = L - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = v;
    hd[0] = d;
    for (int i = 0; i < L; i++) begin
      vv[i]          = hv[L-1-i][i];
      row[i*W +: W]  = hd[L-1-i][i*W +: W];
    end
    if (vv == '1) begin
      m_valid = 1'b1;
      m_data  = row;
      m_cnt   = m_cnt + 1'b1;
    end else begin
      m_valid = 1'b0;
      if (vv != '0) m_err = 1'b1;
    end
  endtask

  function automatic logic [N-1:0] rnd_row();
    logic [N-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // One clock: drive at negedge, update model at posedge, compare just after.
  task automatic step(input logic s, input logic [L-1:0] v, input logic [N-1:0] d);
    @(negedge clk);
    stall    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    if (!s) model_edge(v, d);
    n_vec++;
    step_no++;
    #1;
    chk("out_valid", N'(out_valid), N'(m_valid & ~s));
    chk("out_data", out_data, m_data);
    chk("err_misalign", N'(err_misalign), N'(m_err));
    chk("row_count", N'(row_count), N'(m_cnt));
    if (out_valid === 1'b1) begin
      if (vcount == 0) vfirst = step_no;
      vlast = step_no;
      vcount++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    stall    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    #1;
    model_reset();
    chk("rst_out_valid", N'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_err", N'(err_misalign), '0);
    chk("rst_count", N'(row_count), '0);
    @(negedge clk);
    rst     = 1'b0;
    vcount  = 0;
    base    = step_no;
  endtask

  task automatic sched_clear();
    for (int s = 0; s < SMAX; s++) begin
      sv[s] = '0;
      sd[s] = rnd_row();
    end
  endtask

  // Skewed row: lane i at slot start+i, optionally one lane late.
  task automatic add_row(input int start, input logic [W-1:0] b, input int late_lane, input int late);
    for (int i = 0; i < L; i++) begin
      int t;
      t = start + i + ((i == late_lane) ? late : 0);
      if (t < SMAX) begin
        sv[t][i]       = 1'b1;
        sd[t][i*W +: W] = W'(b + W'(i));
      end
    end
  endtask

  // Play the schedule; a stall holds the upstream position and drives garbage.
  task automatic run_sched(input int len, input int stall_at, input int stall_len, input int pct);
    int idx, sleft;
    bit done;
    idx = 0; sleft = 0; done = 0;
    while (idx < len) begin
      if (!done && idx == stall_at) begin
        sleft = stall_len;
        done  = 1;
      end
      if (sleft > 0) begin
        step(1'b1, L'($urandom), rnd_row());
        sleft--;
      end else if (pct > 0 && int'($urandom_range(99)) < pct) begin
        step(1'b1, L'($urandom), rnd_row());
      end else begin
        step(1'b0, sv[idx], sd[idx]);
        idx++;
      end
    end
  endtask

  localparam logic [N-1:0] ROW10 = {32'h13, 32'h12, 32'h11, 32'h10};

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0; step_no = 0; vcount = 0; vfirst = 0; vlast = 0; base = 0;
    rst = 1'b1; stall = 1'b0; in_valid = '0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Single row: one emission, L edges after lane 0 is sampled.
    do_reset();
    sched_clear();
    add_row(0, 32'h10, -1, 0);
    run_sched(L + 4, -1, 0, 0);
    chk("single_count_valid", N'(vcount), N'(1));
    chk("single_latency", N'(vfirst - base), N'(L));
    chk("single_data", out_data, ROW10);
    chk("single_rows", N'(row_count), N'(1));
    chk("single_err", N'(err_misalign), '0);

    // Stream of 8 back-to-back rows.
    do_reset();
    sched_clear();
    for (int k = 0; k < 8; k++) add_row(k, W'(32'h100 * k), -1, 0);
    run_sched(8 + L + 3, -1, 0, 0);
    chk("stream_valid_cycles", N'(vcount), N'(8));
    chk("stream_contiguous", N'(vlast - vfirst), N'(7));
    chk("stream_last_data", out_data, {32'h703, 32'h702, 32'h701, 32'h700});
    chk("stream_rows", N'(row_count), N'(8));
    chk("stream_err", N'(err_misalign), '0);

    // Stall of 3 cycles after lane 1 is sampled.
    do_reset();
    sched_clear();
    add_row(0, 32'h10, -1, 0);
    run_sched(L + 4, 2, 3, 0);
    chk("stall_count_valid", N'(vcount), N'(1));
    chk("stall_latency", N'(vfirst - base), N'(L + 3));
    chk("stall_data", out_data, ROW10);
    chk("stall_rows", N'(row_count), N'(1));

    // Misaligned row, then a good row that still emits.
    do_reset();
    sched_clear();
    add_row(0, 32'h20, 2, 1);
    add_row(6, 32'h30, -1, 0);
    run_sched(6 + L + 3, -1, 0, 0);
    chk("mis_count_valid", N'(vcount), N'(1));
    chk("mis_err", N'(err_misalign), N'(1));
    chk("mis_rows", N'(row_count), N'(1));
    chk("mis_data", out_data, {32'h33, 32'h32, 32'h31, 32'h30});

    // Asynchronous reset with 2 rows in flight.
    do_reset();
    sched_clear();
    add_row(0, 32'h40, -1, 0);
    add_row(1, 32'h50, -1, 0);
    run_sched(3, -1, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", N'(out_valid), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_err", N'(err_misalign), '0);
    chk("arst_count", N'(row_count), '0);
    @(negedge clk);
    stall = 1'b0; in_valid = '0; in_data = '0;
    rst = 1'b0;
    model_reset();
    vcount = 0;
    base = step_no + 1;
    sched_clear();
    add_row(2, 32'h60, -1, 0);
    run_sched(2 + L + 3, -1, 0, 0);
    chk("arst_fresh_valid", N'(vcount), N'(1));
    chk("arst_fresh_rows", N'(row_count), N'(1));

    // Counter wrap: 17 rows on a 4-bit counter.
    do_reset();
    sched_clear();
    for (int k = 0; k < 17; k++) add_row(k, $urandom, -1, 0);
    run_sched(17 + L + 3, -1, 0, 0);
    chk("wrap_valid_cycles", N'(vcount), N'(17));
    chk("wrap_rows", N'(row_count), N'(1));
    chk("wrap_err", N'(err_misalign), '0);

    // Randomized rows, occasional late lanes, random stalls.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      sched_clear();
      for (int s = 0; s < 300; s++) begin
        if (int'($urandom_range(99)) < 60) begin
          if (pass == 1 && int'($urandom_range(99)) < 5)
            add_row(s, $urandom, int'($urandom_range(L - 1)), 1);
          else
            add_row(s, $urandom, -1, 0);
        end
      end
      run_sched(300 + L + 2, -1, 0, 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
